fft_twiddle_sequencer: RTL and testbench

Streams the twiddle factors for a complete N-point radix-2 DIT FFT in butterfly order. The stream carries a stage index and a butterfly index with each factor. The block sits directly downstream of the twiddle-factor tables (W_N^k = cos(2πk/N) − j·sin(2πk/N), k = 0..N/2−1) and directly upstream of the butterfly datapath. It holds the table as a fixed-point ROM and uses a valid/ready handshake so the butterfly can stall it.

---
 rtl/fft_twiddle_sequencer.sv | 150 +++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer.sv
// Streams radix-2 DIT twiddle factors in butterfly order (stage-major, butterfly-minor)
// from an elaboration-time fixed-point ROM, with a valid/ready output handshake.
module fft_twiddle_sequencer #(
  parameter  int unsigned N     = 64,
  parameter  int unsigned TW_W  = 16,
  localparam int unsigned LOGN  = $clog2(N),
  localparam int unsigned HALF  = N / 2,
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1,
  localparam int unsigned STG_W = (LOGN > 1) ? $clog2(LOGN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [TW_W-1:0]  tw_re,
  output logic [TW_W-1:0]  tw_im,
  output logic [IDX_W-1:0] tw_idx,
  output logic [STG_W-1:0] stage,
  output logic [IDX_W-1:0] bfly_idx
);

  localparam real                PI     = 3.14159265358979323846;
  localparam longint             ONE_Q  = 64'(1) << (TW_W - 1);
  localparam real                SCALE  = real'(ONE_Q);
  localparam logic [IDX_W-1:0]   B_LAST = IDX_W'(HALF - 1);
  localparam logic [STG_W-1:0]   S_LAST = STG_W'(LOGN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [TW_W-1:0]  r_re;
  logic [TW_W-1:0]  r_im;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_b;
  logic [STG_W-1:0] r_s;

  logic             w_fire;
  logic             w_last;
  logic [IDX_W-1:0] w_b_nxt;
  logic [STG_W-1:0] w_s_nxt;
  logic [IDX_W-1:0] w_k_nxt;
  logic [TW_W-1:0]  w_rom_re [HALF];
  logic [TW_W-1:0]  w_rom_im [HALF];

  // Q1.(TW_W-1) ROM: round half away from zero, then saturate (+1.0 clips to max positive).
  for (genvar k = 0; k < int'(HALF); k++) begin : g_rom
    localparam real    ANG    = 2.0 * PI * real'(k) / real'(N);
    localparam real    V_RE   = $cos(ANG) * SCALE;
    localparam real    V_IM   = -$sin(ANG) * SCALE;
    localparam longint RND_RE = (V_RE >= 0.0) ? longint'($rtoi(V_RE + 0.5))
                                              : -longint'($rtoi(0.5 - V_RE));
    localparam longint RND_IM = (V_IM >= 0.0) ? longint'($rtoi(V_IM + 0.5))
                                              : -longint'($rtoi(0.5 - V_IM));
    localparam longint SAT_RE = (RND_RE > ONE_Q - 1) ? ONE_Q - 1 :
                                (RND_RE < -ONE_Q)    ? -ONE_Q    : RND_RE;
    localparam longint SAT_IM = (RND_IM > ONE_Q - 1) ? ONE_Q - 1 :
                                (RND_IM < -ONE_Q)    ? -ONE_Q    : RND_IM;
    assign w_rom_re[k] = TW_W'(SAT_RE);
    assign w_rom_im[k] = TW_W'(SAT_IM);
  end

  // k = (b mod 2^s) * (N >> (s+1)), expressed as mask-and-shift.
  function automatic logic [IDX_W-1:0] k_of(input logic [STG_W-1:0] s,
                                            input logic [IDX_W-1:0] b);
    logic [IDX_W-1:0] mask;
    int unsigned      sh;
    mask = IDX_W'((32'd1 << s) - 32'd1);
    sh   = LOGN - 32'd1 - 32'(s);
    k_of = (b & mask) << sh;
  endfunction

  always_comb begin
    w_fire  = r_valid & tw_ready;
    w_last  = (r_s == S_LAST) && (r_b == B_LAST);
    w_b_nxt = r_b + IDX_W'(1);
    w_s_nxt = r_s;
    if (r_b == B_LAST) begin
      w_b_nxt = '0;
      w_s_nxt = r_s + STG_W'(1);
    end
    w_k_nxt = k_of(w_s_nxt, w_b_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
      r_idx   <= '0;
      r_b     <= '0;
      r_s     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_s     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_re    <= w_rom_re[0];
            r_im    <= w_rom_im[0];
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_s   <= w_s_nxt;
              r_b   <= w_b_nxt;
              r_idx <= w_k_nxt;
              r_re  <= w_rom_re[w_k_nxt];
              r_im  <= w_rom_im[w_k_nxt];
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign tw_valid = r_valid;
  assign tw_re    = r_re;
  assign tw_im    = r_im;
  assign tw_idx   = r_idx;
  assign stage    = r_s;
  assign bfly_idx = r_b;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Bench for fft_twiddle_sequencer: four sizes (N=8,64,4,128) checked against a
// stage/butterfly reference list built from the index and rounding rules.
module tb_fft_twiddle_sequencer;

  localparam int NI = 4;
  localparam logic [NI-1:0][7:0] NS = {8'd128, 8'd4, 8'd64, 8'd8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, start, ready, valid, busy, done;
  logic [15:0]   re_a  [NI];
  logic [15:0]   im_a  [NI];
  logic [7:0]    idx_a [NI];
  logic [7:0]    stg_a [NI];
  logic [7:0]    bf_a  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NN = NS[g];
    localparam int unsigned LG = $clog2(NN);
    localparam int unsigned IW = (NN / 2 > 1) ? $clog2(NN / 2) : 1;
    localparam int unsigned SW = (LG > 1) ? $clog2(LG) : 1;
    logic [IW-1:0] idx_l, bf_l;
    logic [SW-1:0] stg_l;
    logic [15:0]   re_l, im_l;
    fft_twiddle_sequencer #(.N(NN), .TW_W(16)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .tw_valid (valid[g]),
      .tw_ready (ready[g]),
      .tw_re    (re_l),
      .tw_im    (im_l),
      .tw_idx   (idx_l),
      .stage    (stg_l),
      .bfly_idx (bf_l)
    );
    assign re_a[g]  = re_l;
    assign im_a[g]  = im_l;
    assign idx_a[g] = 8'(idx_l);
    assign stg_a[g] = 8'(stg_l);
    assign bf_a[g]  = 8'(bf_l);
  end

  int n_tests = 0;
  int n_fail  = 0;

  int RE8  [4]  = '{32767, 23170, 0, -23170};
  int IM8  [4]  = '{0, -23170, -32768, -23170};
  int IDX8 [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int RE4  [2]  = '{32767, 0};
  int IM4  [2]  = '{0, -32768};

  int es[$], eb[$], ek[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Q1.15 with round-half-away-from-zero and saturation.
  function automatic int q15(input real x);
    real v;
    int  r;
    v = x * 32768.0;
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int ref_re(input int k, input int n);
    return q15($cos(2.0 * 3.14159265358979323846 * real'(k) / real'(n)));
  endfunction

  function automatic int ref_im(input int k, input int n);
    return q15(-$sin(2.0 * 3.14159265358979323846 * real'(k) / real'(n)));
  endfunction

  // Every (s, b) of the sequence in order, with its table index.
  task automatic build(input int n);
    int lg;
    es.delete(); eb.delete(); ek.delete();
    lg = 0;
    while ((1 << lg) < n) lg++;
    for (int s = 0; s < lg; s++)
      for (int b = 0; b < n / 2; b++) begin
        es.push_back(s);
        eb.push_back(b);
        ek.push_back((b % (1 << s)) * (n >> (s + 1)));
      end
  endtask

  task automatic run_seq(input int g, input int pct, input int stall_at, input int stall_len,
                         input int poke_hs, input int rst_hs);
    int n, total, hs, cyc, stall_rem, re, im;
    n = int'(NS[g]);
    build(n);
    total = es.size();
    hs = 0; cyc = 0; stall_rem = stall_len;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    while (hs < total && cyc < total * 4 + 100) begin
      start[g] = 1'b0;
      re = int'($signed(re_a[g]));
      im = int'($signed(im_a[g]));
      chk("valid", int'(valid[g]), 1);
      chk("busy", int'(busy[g]), 1);
      chk("done_low", int'(done[g]), 0);
      chk("stage", int'(stg_a[g]), es[hs]);
      chk("bfly", int'(bf_a[g]), eb[hs]);
      chk("idx", int'(idx_a[g]), ek[hs]);
      chk("re", re, ref_re(ek[hs], n));
      chk("im", im, ref_im(ek[hs], n));
      if (n == 8) begin
        chk("idx8_seq", int'(idx_a[g]), IDX8[hs]);
        chk("re8_const", re, RE8[ek[hs]]);
        chk("im8_const", im, IM8[ek[hs]]);
      end
      if (n == 4) begin
        chk("re4_const", re, RE4[ek[hs]]);
        chk("im4_const", im, IM4[ek[hs]]);
      end
      if (hs == rst_hs) begin
        rst[g] = 1'b1; ready[g] = 1'b0;
        tick();
        rst[g] = 1'b0;
        chk("rst_valid", int'(valid[g]), 0);
        chk("rst_busy", int'(busy[g]), 0);
        chk("rst_done", int'(done[g]), 0);
        chk("rst_re", int'(re_a[g]), 0);
        chk("rst_im", int'(im_a[g]), 0);
        chk("rst_idx", int'(idx_a[g]), 0);
        chk("rst_stage", int'(stg_a[g]), 0);
        chk("rst_bfly", int'(bf_a[g]), 0);
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("rst_no_done", int'(done[g]), 0);
          chk("rst_no_valid", int'(valid[g]), 0);
        end
        return;
      end
      if (hs == poke_hs) start[g] = 1'b1;
      if (hs == stall_at && stall_rem > 0) begin
        ready[g] = 1'b0;
        stall_rem--;
      end else begin
        ready[g] = ($urandom_range(99) < 32'(pct));
      end
      if (ready[g] && valid[g]) hs++;
      tick();
      cyc++;
    end
    start[g] = 1'b0;
    ready[g] = 1'b0;
    chk("hs_count", hs, total);
    chk("done_pulse", int'(done[g]), 1);
    chk("valid_after", int'(valid[g]), 0);
    chk("busy_in_done", int'(busy[g]), 1);
    tick();
    chk("done_clear", int'(done[g]), 0);
    chk("busy_clear", int'(busy[g]), 0);
    chk("valid_idle", int'(valid[g]), 0);
  endtask

  initial begin
    rst = '1; start = '0; ready = '0;
    repeat (3) tick();
    rst = '0;
    tick();
    for (int g = 0; g < NI; g++) begin
      chk("reset_valid", int'(valid[g]), 0);
      chk("reset_busy", int'(busy[g]), 0);
      chk("reset_done", int'(done[g]), 0);
      chk("reset_re", int'(re_a[g]), 0);
      chk("reset_idx", int'(idx_a[g]), 0);
    end
    run_seq(0, 100, -1, 0, -1, -1);
    run_seq(0, 100, 5, 5, -1, -1);
    run_seq(0, 100, -1, 0, 3, -1);
    run_seq(0, 100, -1, 0, -1, 6);
    run_seq(0, 70, -1, 0, -1, -1);
    run_seq(1, 50, -1, 0, -1, -1);
    run_seq(2, 100, -1, 0, -1, -1);
    run_seq(3, 100, -1, 0, -1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
